// File: rtl/clk_div_meter_pkg.sv
// Shared types and defaults for the divided-clock meter.
package clk_div_meter_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned TIMEOUT_DEF     = 65535;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HIGH,
        LOW,
        DONE
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, followed by one extra
// flop so the synchronised level can be compared against its previous value.
module sync_edge_det
    import clk_div_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/clk_div_meter.sv
// Measures high time, low time and period of an asynchronous clock in
// system-clock cycles, one measurement per start pulse, with a per-phase timeout.
module clk_div_meter
    import clk_div_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W-1:0] period,
    output logic             duty_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             duty_q, duty_d;
    logic             to_q, to_d;
    logic             sig_level_unused;
    logic             rise_det, fall_det;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .level    (sig_level_unused),
        .rise     (rise_det),
        .fall     (fall_det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            duty_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            high_q   <= high_d;
            low_q    <= low_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            to_q     <= to_d;
        end
    end

    // A terminating edge always wins over the timeout on the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        high_d   = high_q;
        low_d    = low_q;
        period_d = period_q;
        duty_d   = duty_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    high_d   = '0;
                    low_d    = '0;
                    period_d = '0;
                    duty_d   = 1'b0;
                    to_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (rise_det) begin
                    cnt_d   = CNT_ONE;
                    state_d = HIGH;
                end else if (cnt_q == CNT_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (fall_det) begin
                    high_d  = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = LOW;
                end else if (cnt_q == CNT_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOW: begin
                if (rise_det) begin
                    low_d    = cnt_q;
                    period_d = high_q + cnt_q;
                    duty_d   = (high_q == cnt_q);
                    state_d  = DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ARM) || (state_q == HIGH) || (state_q == LOW);
    assign done     = (state_q == DONE);
    assign high_cnt = high_q;
    assign low_cnt  = low_q;
    assign period   = period_q;
    assign duty_ok  = duty_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Self-checking bench for clk_div_meter: directed vectors, boundary sequences
// and randomized high/low lengths checked against a behavioural model.
module tb_clk_div_meter;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TO    = 100;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             sig_in  = 1'b0;
    logic             start   = 1'b0;
    logic             busy, done, duty_ok, timeout;
    logic [CNT_W-1:0] high_cnt, low_cnt, period;

    int unsigned checks    = 0;
    int unsigned errors    = 0;
    int unsigned done_seen = 0;

    bit          gen_run   = 1'b0;
    logic        gen_level = 1'b0;
    int unsigned gen_h     = 1;
    int unsigned gen_l     = 1;
    int unsigned gen_ph    = 0;

    typedef struct {
        int unsigned high;
        int unsigned low;
        int unsigned per;
        bit          duty;
        bit          to;
    } res_t;

    typedef struct {
        int unsigned h;
        int unsigned l;
        res_t        exp;
    } vec_t;

    clk_div_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .high_cnt (high_cnt),
        .low_cnt  (low_cnt),
        .period   (period),
        .duty_ok  (duty_ok),
        .timeout  (timeout)
    );

    always #20 clk = ~clk;

    // Divider-style source: h cycles high, l cycles low, or a static level.
    always @(posedge clk) begin
        #5;
        if (gen_run) begin
            sig_in = (gen_ph < gen_h);
            gen_ph = (gen_ph + 1 >= gen_h + gen_l) ? 0 : gen_ph + 1;
        end else begin
            sig_in = gen_level;
            gen_ph = 0;
        end
    end

    always @(negedge clk) if (done) done_seen <= done_seen + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input int unsigned h, input int unsigned l);
        res_t r;
        r = '{high: 0, low: 0, per: 0, duty: 1'b0, to: 1'b0};
        if (h > TO) begin
            r.to = 1'b1;
        end else if (l > TO) begin
            r.to   = 1'b1;
            r.high = h;
        end else begin
            r.high = h;
            r.low  = l;
            r.per  = (h + l) % (1 << CNT_W);
            r.duty = (h == l);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_wait", done, 1);
    endtask

    task automatic check_res(input string tag, input res_t e);
        chk($sformatf("%s.high", tag), high_cnt, e.high);
        chk($sformatf("%s.low", tag), low_cnt, e.low);
        chk($sformatf("%s.period", tag), period, e.per);
        chk($sformatf("%s.duty", tag), duty_ok, e.duty);
        chk($sformatf("%s.timeout", tag), timeout, e.to);
        chk($sformatf("%s.busy_at_done", tag), busy, 0);
        @(negedge clk);
        chk($sformatf("%s.done_pulse", tag), done, 0);
        chk($sformatf("%s.busy_after", tag), busy, 0);
    endtask

    task automatic set_pattern(input int unsigned h, input int unsigned l);
        @(negedge clk);
        gen_run   = 1'b0;
        gen_level = 1'b0;
        gen_h     = h;
        gen_l     = l;
        @(negedge clk) gen_run = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int unsigned h, input int unsigned l, input res_t e);
        int unsigned cyc;
        set_pattern(h, l);
        pulse_start();
        chk($sformatf("%s.busy_start", tag), busy, 1);
        wait_done(400, cyc);
        check_res(tag, e);
    endtask

    // th/tl = 0 means that phase is held forever.
    task automatic directed(input string tag, input int unsigned th, input int unsigned tl, input res_t e);
        int unsigned cyc;
        @(negedge clk);
        gen_run   = 1'b0;
        gen_level = 1'b0;
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        gen_level = 1'b1;
        if (th != 0) begin
            repeat (th) @(negedge clk);
            gen_level = 1'b0;
            if (tl != 0) begin
                repeat (tl) @(negedge clk);
                gen_level = 1'b1;
            end
        end
        wait_done(400, cyc);
        check_res(tag, e);
        gen_level = 1'b0;
    endtask

    initial begin
        vec_t        vecs[6];
        res_t        e;
        int unsigned cyc, d0, h, l;

        vecs[0] = '{h: 20, l: 20, exp: '{high: 20, low: 20, per: 40,  duty: 1'b1, to: 1'b0}};
        vecs[1] = '{h: 3,  l: 5,  exp: '{high: 3,  low: 5,  per: 8,   duty: 1'b0, to: 1'b0}};
        vecs[2] = '{h: 1,  l: 1,  exp: '{high: 1,  low: 1,  per: 2,   duty: 1'b1, to: 1'b0}};
        vecs[3] = '{h: 7,  l: 6,  exp: '{high: 7,  low: 6,  per: 13,  duty: 1'b0, to: 1'b0}};
        vecs[4] = '{h: 1,  l: 2,  exp: '{high: 1,  low: 2,  per: 3,   duty: 1'b0, to: 1'b0}};
        vecs[5] = '{h: 50, l: 50, exp: '{high: 50, low: 50, per: 100, duty: 1'b1, to: 1'b0}};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.high", high_cnt, 0);
        chk("rst.low", low_cnt, 0);
        chk("rst.period", period, 0);
        chk("rst.duty", duty_ok, 0);
        chk("rst.timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel.busy", busy, 0);

        for (int i = 0; i < 6; i++)
            measure($sformatf("vec%0d", i), vecs[i].h, vecs[i].l, vecs[i].exp);

        // Stuck-low input: ARM timeout
        @(negedge clk);
        gen_run   = 1'b0;
        gen_level = 1'b0;
        repeat (5) @(negedge clk);
        pulse_start();
        chk("to_arm.busy_start", busy, 1);
        wait_done(400, cyc);
        chk("to_arm.latency", cyc, TO + 1);
        check_res("to_arm", '{high: 0, low: 0, per: 0, duty: 1'b0, to: 1'b1});

        // Phase lengths at and just past the timeout limit
        directed("hi_eq_to", TO, 5, '{high: TO, low: 5, per: TO + 5, duty: 1'b0, to: 1'b0});
        directed("lo_eq_to", 5, TO, '{high: 5, low: TO, per: TO + 5, duty: 1'b0, to: 1'b0});
        directed("hi_to", 0, 0, '{high: 0, low: 0, per: 0, duty: 1'b0, to: 1'b1});
        directed("lo_to", 5, 0, '{high: 5, low: 0, per: 0, duty: 1'b0, to: 1'b1});

        // Second start while busy is ignored; a later start clears and re-measures
        set_pattern(20, 20);
        d0 = done_seen;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(400, cyc);
        check_res("restart_busy", model(20, 20));
        @(negedge clk);
        chk("restart_busy.done_count", done_seen, d0 + 1);
        set_pattern(3, 5);
        chk("hold.high", high_cnt, 20);
        chk("hold.period", period, 40);
        pulse_start();
        chk("clear.high", high_cnt, 0);
        chk("clear.low", low_cnt, 0);
        chk("clear.period", period, 0);
        chk("clear.duty", duty_ok, 0);
        wait_done(400, cyc);
        check_res("remeasure", model(3, 5));

        // Reset in the middle of the HIGH phase
        @(negedge clk);
        gen_run   = 1'b0;
        gen_level = 1'b0;
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        gen_level = 1'b1;
        repeat (10) @(negedge clk);
        d0 = done_seen;
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.high", high_cnt, 0);
        chk("midrst.timeout", timeout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.no_done", done_seen, d0);
        chk("midrst.busy_after", busy, 0);
        measure("post_rst", 3, 5, model(3, 5));

        // Randomized high/low lengths against the model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                h = $urandom_range(TO + 1, TO + 30);
                l = $urandom_range(1, 5);
            end else begin
                h = $urandom_range(1, 60);
                l = $urandom_range(1, 40);
            end
            measure($sformatf("rnd%0d_h%0d_l%0d", i, h, l), h, l, model(h, l));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
